// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// and decodes per-state datapath strobes, ALU operation class and PC muxing.
module mips_main_control #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               retire,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = STATE_W'(0),
    S_DECODE    = STATE_W'(1),
    S_MEM_ADDR  = STATE_W'(2),
    S_MEM_READ  = STATE_W'(3),
    S_MEM_WB    = STATE_W'(4),
    S_MEM_WRITE = STATE_W'(5),
    S_EXECUTE   = STATE_W'(6),
    S_R_WB      = STATE_W'(7),
    S_BRANCH    = STATE_W'(8),
    S_JUMP      = STATE_W'(9)
  } state_t;

  state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    retire        = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        retire    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Outputs are silenced for the whole reset interval, not just after the edge.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      retire        = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: directed steps plus random
// instruction streams compared against a step-plan reference model.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  mips_main_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ILL = 6'b111111;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: current step code plus the remaining steps of the instruction.
  int m_state = 0;
  int plan[$];
  bit last_retire;

  wire [17:0] got = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, retire, illegal_op};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == JMP;
  endfunction

  // Expected strobes for one step, straight from the per-step output table.
  function automatic logic [17:0] exp_out(int s, bit mr, logic [5:0] op);
    bit pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0;
    bit rw = 0, asa = 0, ret = 0, ill = 0;
    bit [1:0] asb = 0, aop = 0, psrc = 0;
    case (s)
      0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      1: begin asb = 2'b11; ill = !legal(op); end
      2: begin asa = 1; asb = 2'b10; end
      3: begin mrd = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; ret = 1; end
      5: begin mwr = 1; iod = 1; ret = mr; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; ret = 1; end
      8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; ret = 1; end
      9: begin pw = 1; psrc = 2'b10; ret = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ret, ill};
  endfunction

  function automatic void load_plan(logic [5:0] op);
    plan.delete();
    case (op)
      LW:  plan = '{2, 3, 4};
      SW:  plan = '{2, 5};
      RT:  plan = '{6, 7};
      BEQ: plan = '{8};
      JMP: plan = '{9};
      default: ;
    endcase
  endfunction

  function automatic void model_advance(logic [5:0] op, bit mr);
    if (m_state == 1) load_plan(op);
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !mr) return;
    if (m_state == 0) m_state = 1;
    else m_state = (plan.size() > 0) ? plan.pop_front() : 0;
  endfunction

  task automatic cycle(input logic [5:0] op, input bit mr);
    @(negedge clk);
    opcode = op;
    mem_ready = mr;
    #1;
    check("state", 32'(state), 32'(m_state));
    check("outputs", 32'(got), 32'(exp_out(m_state, mr, op)));
    last_retire = retire;
    @(posedge clk);
    model_advance(op, mr);
  endtask

  task automatic latency(input logic [5:0] op, input int exp_cycles);
    int n = 0;
    do begin
      cycle(op, 1'b1);
      n++;
    end while (!last_retire && n < 20);
    check($sformatf("latency_%b", op), 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    logic [5:0] cur_op;
    int pick;
    reset = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outputs", 32'(got), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Latency of every instruction class with memory always ready.
    latency(LW, 5);
    latency(SW, 4);
    latency(RT, 4);
    latency(BEQ, 3);
    latency(JMP, 3);

    // Stalled fetch, then illegal opcode: no retire, back to fetch.
    cycle(ILL, 1'b0);
    cycle(ILL, 1'b0);
    cycle(ILL, 1'b1);
    cycle(ILL, 1'b1);
    check("illegal_seen_no_retire", 32'(last_retire), 32'd0);
    cycle(LW, 1'b0);

    // sw with three wait cycles in MEM_WRITE.
    cycle(SW, 1'b1);
    cycle(SW, 1'b1);
    cycle(SW, 1'b1);
    repeat (3) cycle(SW, 1'b0);
    cycle(SW, 1'b1);
    check("sw_retire_on_ready", 32'(last_retire), 32'd1);

    // Asynchronous reset while lw waits in MEM_READ.
    cycle(LW, 1'b1);
    cycle(LW, 1'b1);
    cycle(LW, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("pre_reset_mem_read", 32'(state), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_outputs", 32'(got), 32'd0);
    m_state = 0;
    plan.delete();
    @(posedge clk);
    #1;
    check("reset_held_state", 32'(state), 32'd0);
    check("reset_held_outputs", 32'(got), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cycle(LW, 1'b1);
    cycle(LW, 1'b1);

    // Random instruction stream with random memory wait states.
    cur_op = LW;
    for (int i = 0; i < 400; i++) begin
      if (m_state == 0) begin
        pick = $urandom_range(0, 5);
        case (pick)
          0: cur_op = LW;
          1: cur_op = SW;
          2: cur_op = RT;
          3: cur_op = BEQ;
          4: cur_op = JMP;
          default: cur_op = 6'($urandom);
        endcase
      end
      cycle(cur_op, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_main_control.md
Name: mips_main_control

Overview:
- Multicycle MIPS main control FSM that generates `alu_op` for the ALU control decoder, plus all datapath strobes and muxes for each instruction step.
- Decodes the 6-bit opcode from the instruction register (IR) and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Memory accesses use a `mem_ready` handshake.
- Supported instructions: lw, sw, R-type, beq, j. All other opcodes are flagged as illegal.

Parameters:
- `STATE_W`, 4, width of the state register and of the `state` debug output.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `opcode`  input  6  IR[31:26]; stable from DECODE until the instruction retires.
- `mem_ready`  input  1  memory completes the current read/write this cycle.
- `pc_write`  output  1  unconditional PC load.
- `pc_write_cond`  output  1  PC load if ALU zero (beq).
- `i_or_d`  output  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`  output  1  memory read request.
- `mem_write`  output  1  memory write request.
- `ir_write`  output  1  IR load.
- `mem_to_reg`  output  1  write-back data: 0 = ALUOut, 1 = MDR.
- `reg_dst`  output  1  destination register: 0 = rt, 1 = rd.
- `reg_write`  output  1  register file write.
- `alu_src_a`  output  1  ALU A input: 0 = PC, 1 = A register.
- `alu_src_b`  output  2  ALU B input: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `alu_op`  output  2  00 = add (lw/sw/PC), 01 = subtract (beq), 10 = R-type (decode `funct`); 11 is never driven.
- `pc_source`  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `retire`  output  1  one-cycle pulse in the final state of each instruction.
- `illegal_op`  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `state`  output  `STATE_W`  current state, for debug and verification.

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, EXECUTE = 6, R_WB = 7, BRANCH = 8, JUMP = 9.
- Codes 10–15 are unreachable; if entered, go to FETCH on the next edge with all outputs 0.
- Reset:
  - `reset` high forces `state` = FETCH immediately (asynchronous).
  - While `reset` is high, every output except `state` is 0.
  - Reset asserted mid-instruction aborts it: no `retire`, no pending writes.
- Outputs are Moore (decoded from state) except where gated by `mem_ready` as listed. Any output not listed for a state is 0.
- FETCH:
  - `mem_read` = 1, `i_or_d` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `alu_op` = 00, `pc_source` = 00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Stays in FETCH until `mem_ready` = 1, then goes to DECODE.
- DECODE:
  - `alu_src_a` = 0, `alu_src_b` = 11, `alu_op` = 00.
  - Opcode 100011 (lw) or 101011 (sw) → MEM_ADDR.
  - Opcode 000000 (R-type) → EXECUTE.
  - Opcode 000100 (beq) → BRANCH.
  - Opcode 000010 (j) → JUMP.
  - Any other opcode → FETCH, with `illegal_op` = 1 this cycle.
- MEM_ADDR:
  - `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00.
  - lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ:
  - `mem_read` = 1, `i_or_d` = 1.
  - Holds until `mem_ready`, then → MEM_WB.
- MEM_WB:
  - `reg_write` = 1, `mem_to_reg` = 1, `reg_dst` = 0, `retire` = 1.
  - → FETCH.
- MEM_WRITE:
  - `mem_write` = 1, `i_or_d` = 1, `retire` = `mem_ready`.
  - Holds until `mem_ready`, then → FETCH.
- EXECUTE:
  - `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 10.
  - → R_WB.
- R_WB:
  - `reg_write` = 1, `reg_dst` = 1, `mem_to_reg` = 0, `retire` = 1.
  - → FETCH.
- BRANCH:
  - `alu_src_a` = 1, `alu_src_b` = 00, `alu_op` = 01, `pc_write_cond` = 1, `pc_source` = 01, `retire` = 1.
  - → FETCH.
- JUMP:
  - `pc_write` = 1, `pc_source` = 10, `retire` = 1.
  - → FETCH.
- Latency with `mem_ready` tied to 1: lw 5 cycles, sw 4, R-type 4, beq 3, j 3. Each cycle with `mem_ready` = 0 in a memory state adds one cycle.
- `mem_read` and `mem_write` are never both 1.
- `reg_write` and `mem_write` are never both 1.
- Opcode changes outside DECODE/MEM_ADDR are ignored.

Test Plan:
- Reset: assert `reset` mid-MEM_READ (`opcode` = 100011) → `state` = 0 asynchronously, all strobes 0. After release with `mem_ready` = 1, the next edge goes to DECODE.
- lw, `mem_ready` = 1: state sequence 0, 1, 2, 3, 4, 0. `alu_op` = 00 in MEM_ADDR; `reg_write` = `mem_to_reg` = 1 and `retire` = 1 in MEM_WB only.
- R-type (`opcode` = 000000) → `alu_op` = 10 in EXECUTE; R_WB has `reg_dst` = 1, `reg_write` = 1. Four cycles from FETCH to `retire`.
- beq (000100) → BRANCH drives `alu_op` = 01, `pc_write_cond` = 1, `pc_source` = 01. j (000010) → `pc_write` = 1, `pc_source` = 10. Each takes 3 cycles.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write` held 1 for 4 cycles; `retire` pulses only on the `mem_ready` cycle; `reg_write` stays 0.
- Illegal opcode 111111 in DECODE → `illegal_op` = 1 for one cycle, next state FETCH, no `retire`. Also stall FETCH with `mem_ready` = 0: `ir_write` and `pc_write` stay 0.
